cp0_exc_unit: RTL and testbench

Coprocessor-0 exception responder for the five-stage MIPS pipeline. Consumes the exception codes raised by the fetch, decode and execute checkers, merges them with the six hardware interrupt lines at the M stage, and decides whether to take an exception. When it takes one, it records EPC, Cause and SR.EXL. It also serves `mfc0`/`mtc0` and `eret`, and drives the return address back to the PC-select logic.

---
 rtl/cp0_exc_unit.sv | 141 ++++++++++++++
 tb/tb_cp0_exc_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/cp0_exc_unit.sv
// CP0 exception responder: takes M-stage exceptions/interrupts, records EPC/Cause/SR.EXL, serves mfc0/mtc0/eret.
// Optional macro CP0_BD_EN: branch-delay-slot tracking (Cause.BD and EPC rewind by 4).
module cp0_exc_unit #(
   parameter logic [31:0] PRID    = 32'h4D495053,
   parameter logic [31:0] HANDLER = 32'h00004180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m_valid,
   input  logic [31:0] pc_m,
   input  logic        bd_m,
   input  logic [4:0]  exccode_m,
   input  logic        eret_m,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   input  logic [5:0]  hwint,
   output logic [31:0] rdata,
   output logic        exc_req,
   output logic [31:0] handler_pc,
   output logic [31:0] epc_out
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned IW   = 6;
   localparam int unsigned EW   = 5;

   localparam logic [4:0] A_SR    = 5'd12;
   localparam logic [4:0] A_CAUSE = 5'd13;
   localparam logic [4:0] A_EPC   = 5'd14;
   localparam logic [4:0] A_PRID  = 5'd15;

   // The state register doubles as SR.EXL.
   typedef enum logic {
      ST_NORMAL  = 1'b0,
      ST_HANDLER = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     im_q, im_d;
   logic              ie_q, ie_d;
   logic [IW-1:0]     ip_q, ip_d;
   logic [EW-1:0]     exc_q, exc_d;
   logic              bd_q, bd_d;
   logic [XLEN-1:0]   epc_q, epc_d;

   logic              exl;
   logic              int_req;
   logic              exc_pend;
   logic              sr_wr;
   logic              epc_wr;
   logic              bd_cap;
   logic [XLEN-1:0]   epc_cap;

   assign exl      = (state_q == ST_HANDLER);
   assign int_req  = m_valid & ie_q & ~exl & (|(hwint & im_q));
   assign exc_pend = m_valid & ~exl & (exccode_m != EW'(0));
   assign exc_req  = int_req | exc_pend;
   assign sr_wr    = we & (addr == A_SR);
   assign epc_wr   = we & (addr == A_EPC);

   assign handler_pc = HANDLER;
   assign epc_out    = epc_wr ? wdata : epc_q;

`ifdef CP0_BD_EN
   assign bd_cap  = bd_m;
   assign epc_cap = bd_m ? (pc_m - XLEN'(4)) : pc_m;
`else
   logic unused_bd;
   assign unused_bd = bd_m;
   assign bd_cap    = 1'b0;
   assign epc_cap   = pc_m;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_NORMAL;
         im_q    <= '0;
         ie_q    <= 1'b0;
         ip_q    <= '0;
         exc_q   <= '0;
         bd_q    <= 1'b0;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         im_q    <= im_d;
         ie_q    <= ie_d;
         ip_q    <= ip_d;
         exc_q   <= exc_d;
         bd_q    <= bd_d;
         epc_q   <= epc_d;
      end
   end

   // Update priority: exception, then eret (with SR mask write), then plain mtc0.
   always_comb begin
      state_d = state_q;
      im_d    = im_q;
      ie_d    = ie_q;
      ip_d    = hwint;
      exc_d   = exc_q;
      bd_d    = bd_q;
      epc_d   = epc_q;
      if (exc_req) begin
         state_d = ST_HANDLER;
         exc_d   = int_req ? EW'(0) : exccode_m;
         bd_d    = bd_cap;
         epc_d   = epc_cap;
      end else if (eret_m) begin
         state_d = ST_NORMAL;
         if (sr_wr) begin
            im_d = wdata[15:10];
            ie_d = wdata[0];
         end
         if (epc_wr) begin
            epc_d = wdata;
         end
      end else if (we) begin
         if (sr_wr) begin
            im_d    = wdata[15:10];
            ie_d    = wdata[0];
            state_d = wdata[1] ? ST_HANDLER : ST_NORMAL;
         end
         if (epc_wr) begin
            epc_d = wdata;
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         A_SR:    rdata = {16'h0, im_q, 8'h0, exl, ie_q};
         A_CAUSE: rdata = {bd_q, 15'h0, ip_q, 3'h0, exc_q, 2'h0};
         A_EPC:   rdata = epc_q;
         A_PRID:  rdata = PRID;
         default: rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed table-driven bench for cp0_exc_unit; each record is one cycle of stimulus plus expected outputs.
module tb_cp0_exc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        m_valid;
   logic [31:0] pc_m;
   logic        bd_m;
   logic [4:0]  exccode_m;
   logic        eret_m;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [5:0]  hwint;
   logic [31:0] rdata;
   logic        exc_req;
   logic [31:0] handler_pc;
   logic [31:0] epc_out;

   int checks = 0;
   int passes = 0;

`ifdef CP0_BD_EN
   localparam bit BD_EN = 1'b1;
`else
   localparam bit BD_EN = 1'b0;
`endif

   cp0_exc_unit dut (
      .clk(clk), .reset(reset), .m_valid(m_valid), .pc_m(pc_m), .bd_m(bd_m),
      .exccode_m(exccode_m), .eret_m(eret_m), .we(we), .addr(addr), .wdata(wdata),
      .hwint(hwint), .rdata(rdata), .exc_req(exc_req), .handler_pc(handler_pc),
      .epc_out(epc_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        mv;
      logic [31:0] pc;
      logic        bd;
      logic [4:0]  ec;
      logic        er;
      logic        w;
      logic [4:0]  ad;
      logic [31:0] wd;
      logic [5:0]  hw;
      logic        x_req;
      logic [31:0] x_rd;
      logic [31:0] x_epc;
      logic        chk_epc;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst_n, input logic mv, input logic [31:0] pc, input logic bd,
                      input logic [4:0] ec, input logic er, input logic w, input logic [4:0] ad,
                      input logic [31:0] wd, input logic [5:0] hw, input logic x_req,
                      input logic [31:0] x_rd, input logic [31:0] x_epc, input logic chk_epc);
      vec_t v;
      v = '{rst_n, mv, pc, bd, ec, er, w, ad, wd, hw, x_req, x_rd, x_epc, chk_epc};
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic drive(input vec_t v);
      reset = v.rst_n; m_valid = v.mv; pc_m = v.pc; bd_m = v.bd; exccode_m = v.ec;
      eret_m = v.er; we = v.w; addr = v.ad; wdata = v.wd; hwint = v.hw;
   endtask

   task automatic idle_read(input logic [4:0] a);
      reset = 1'b1; m_valid = 1'b0; pc_m = '0; bd_m = 1'b0; exccode_m = '0;
      eret_m = 1'b0; we = 1'b0; addr = a; wdata = '0; hwint = '0;
   endtask

   initial begin
      logic [31:0] bd_epc, bd_cause, wrap_epc, cause_now;
      bd_epc   = BD_EN ? 32'h00003004 : 32'h00003008;
      bd_cause = BD_EN ? 32'h80000030 : 32'h00000030;
      wrap_epc = BD_EN ? 32'hFFFFFFFC : 32'h00000000;

      //   rst mv  pc            bd ec     er w  ad     wd            hw     req rd            epc           ce
      add(1, 0, 32'h0,        0, 5'd0,  0, 0, 5'd13, 32'h0,        6'h00, 0, 32'h00000000, 32'h0,        1);
      add(1, 0, 32'h0,        0, 5'd0,  0, 0, 5'd14, 32'h0,        6'h00, 0, 32'h00000000, 32'h0,        1);
      add(1, 0, 32'h0,        0, 5'd0,  0, 0, 5'd15, 32'h0,        6'h00, 0, 32'h4D495053, 32'h0,        1);
      add(1, 1, 32'h1000,     0, 5'd0,  0, 0, 5'd12, 32'h0,        6'h3F, 0, 32'h00000000, 32'h0,        1);
      add(1, 0, 32'h0,        0, 5'd0,  0, 0, 5'd13, 32'h0,        6'h00, 0, 32'h0000FC00, 32'h0,        1);
      add(1, 1, 32'h00002FFC, 0, 5'd4,  0, 0, 5'd13, 32'h0,        6'h00, 1, 32'h00000000, 32'h0,        1);
      add(1, 0, 32'h0,        0, 5'd0,  0, 0, 5'd13, 32'h0,        6'h00, 0, 32'h00000010, 32'h00002FFC, 1);
      add(1, 0, 32'h0,        0, 5'd0,  0, 0, 5'd14, 32'h0,        6'h00, 0, 32'h00002FFC, 32'h00002FFC, 1);
      add(1, 1, 32'h2004,     0, 5'd10, 0, 0, 5'd12, 32'h0,        6'h00, 0, 32'h00000002, 32'h00002FFC, 1);
      add(1, 1, 32'h2008,     0, 5'd0,  1, 0, 5'd12, 32'h0,        6'h00, 0, 32'h00000002, 32'h00002FFC, 1);
      add(1, 0, 32'h0,        0, 5'd0,  0, 1, 5'd12, 32'h00000401, 6'h00, 0, 32'h00000000, 32'h00002FFC, 1);
      add(1, 1, 32'h00002000, 0, 5'd10, 0, 0, 5'd12, 32'h0,        6'h01, 1, 32'h00000401, 32'h00002FFC, 1);
      add(1, 1, 32'h2010,     0, 5'd0,  0, 0, 5'd13, 32'h0,        6'h01, 0, 32'h00000400, 32'h00002000, 1);
      add(1, 1, 32'h2014,     0, 5'd0,  0, 0, 5'd12, 32'h0,        6'h00, 0, 32'h00000403, 32'h00002000, 1);
      add(1, 0, 32'h0,        0, 5'd0,  0, 1, 5'd12, 32'h00000401, 6'h00, 0, 32'h00000403, 32'h00002000, 1);
      add(1, 0, 32'h0,        0, 5'd0,  0, 0, 5'd12, 32'h0,        6'h01, 0, 32'h00000401, 32'h00002000, 1);
      add(1, 1, 32'h00002100, 0, 5'd0,  0, 1, 5'd14, 32'h00001234, 6'h01, 1, 32'h00002000, 32'h00001234, 1);
      add(1, 0, 32'h0,        0, 5'd0,  0, 0, 5'd14, 32'h0,        6'h00, 0, 32'h00002100, 32'h00002100, 1);
      add(1, 1, 32'h2200,     0, 5'd0,  1, 1, 5'd14, 32'h00003100, 6'h00, 0, 32'h00002100, 32'h00003100, 1);
      add(1, 0, 32'h0,        0, 5'd0,  0, 0, 5'd12, 32'h0,        6'h00, 0, 32'h00000401, 32'h0,        0);
      add(0, 1, 32'h00004000, 0, 5'd5,  0, 0, 5'd12, 32'h0,        6'h00, 1, 32'h00000401, 32'h0,        0);
      add(1, 0, 32'h0,        0, 5'd0,  0, 0, 5'd13, 32'h0,        6'h00, 0, 32'h00000000, 32'h0,        1);
      add(1, 0, 32'h0,        0, 5'd0,  0, 0, 5'd12, 32'h0,        6'h00, 0, 32'h00000000, 32'h0,        1);
      add(1, 1, 32'h00003008, 1, 5'd12, 0, 0, 5'd14, 32'h0,        6'h00, 1, 32'h00000000, 32'h0,        1);
      add(1, 0, 32'h0,        0, 5'd0,  0, 0, 5'd13, 32'h0,        6'h00, 0, bd_cause,     bd_epc,       1);
      add(1, 1, 32'h3010,     0, 5'd0,  1, 0, 5'd14, 32'h0,        6'h00, 0, bd_epc,       bd_epc,       1);
      add(1, 1, 32'h00000000, 1, 5'd5,  0, 0, 5'd12, 32'h0,        6'h00, 1, 32'h00000000, bd_epc,       1);
      add(1, 0, 32'h0,        0, 5'd0,  0, 0, 5'd14, 32'h0,        6'h00, 0, wrap_epc,     wrap_epc,     1);

      idle_read(5'd0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      chk("handler_pc", handler_pc, 32'h00004180);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive(vq[i]);
         #1;
         chk($sformatf("v%0d exc_req", i), 32'(exc_req), 32'(vq[i].x_req));
         chk($sformatf("v%0d rdata", i), rdata, vq[i].x_rd);
         if (vq[i].chk_epc) chk($sformatf("v%0d epc_out", i), epc_out, vq[i].x_epc);
      end

      // Cause, PRId and unimplemented addresses ignore mtc0.
      cause_now = BD_EN ? 32'h80000014 : 32'h00000014;
      @(negedge clk); idle_read(5'd13); we = 1'b1; wdata = 32'hFFFFFFFF;
      @(negedge clk); idle_read(5'd15); we = 1'b1; wdata = 32'h0;
      @(negedge clk); idle_read(5'd7);  we = 1'b1; wdata = 32'hFFFFFFFF;
      @(negedge clk); idle_read(5'd13); #1 chk("cause_ro", rdata, cause_now);
      @(negedge clk); idle_read(5'd15); #1 chk("prid_ro", rdata, 32'h4D495053);
      @(negedge clk); idle_read(5'd7);  #1 chk("unimpl_rd", rdata, 32'h0);
      // SR write clears EXL and reenables exceptions.
      @(negedge clk); idle_read(5'd12); we = 1'b1; wdata = 32'hFFFFFFFD;
      @(negedge clk); idle_read(5'd12); #1 chk("sr_mask", rdata, 32'h0000FC01);
      m_valid = 1'b1; exccode_m = 5'd10; #1 chk("exc_after_sr", 32'(exc_req), 32'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
